spi_status_ctrl: RTL and testbench

- Parametrised SPI status-register block holding N_FLAGS sticky status flags: bit 7 SPIF, bit 5 SPTEF, and further flags as needed.
- Flags are set and cleared by hardware event pulses from the SPI core.
- Software clears flags either by write-1-to-clear or by the SPI read-status-then-access-data sequence.
- Adds per-flag overrun detection and a masked interrupt output.
- Sits between the SPI shift/control core and the CPU register interface.

---
 rtl/spi_status_ctrl.sv | 79 +++++++
 tb/tb_spi_status_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/spi_status_ctrl.sv
// SPI status register: sticky per-flag status bits set/cleared by core events,
// software clear by write-1-to-clear or read-status-then-access-data, per-flag
// overrun capture and a masked interrupt request.
module spi_status_ctrl #(
    parameter int          N_FLAGS  = 8,
    parameter logic [31:0] RST_VAL  = 32'h0000_0000,
    parameter bit          CLR_MODE = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_FLAGS-1:0] hw_set,
    input  logic [N_FLAGS-1:0] hw_clr,
    input  logic               sr_rd,
    input  logic               dr_acc,
    input  logic               wr_en,
    input  logic [N_FLAGS-1:0] wr_data,
    input  logic [N_FLAGS-1:0] irq_en,
    output logic [N_FLAGS-1:0] status,
    output logic [N_FLAGS-1:0] ovr,
    output logic               irq
);

    // Only the low N_FLAGS bits of the reset value are meaningful.
    localparam logic [N_FLAGS-1:0] RST_STATUS = RST_VAL[N_FLAGS-1:0];

    // Flags the CPU saw set at its last status read; only used in sequence mode.
    logic [N_FLAGS-1:0] armed;

    logic [N_FLAGS-1:0] sw_clr;
    logic [N_FLAGS-1:0] any_clr;
    logic [N_FLAGS-1:0] ovr_set;
    logic [N_FLAGS-1:0] status_nxt;
    logic [N_FLAGS-1:0] ovr_nxt;
    logic [N_FLAGS-1:0] armed_nxt;

    // Next-state for status, overrun and armed; hw_set beats every clear.
    always_comb begin
        sw_clr    = '0;
        armed_nxt = '0;
        if (CLR_MODE) begin
            sw_clr = dr_acc ? armed : '0;
            // A data access consumes the armed set; a status read in the same
            // cycle re-arms from the pre-update status.
            if (sr_rd)
                armed_nxt = status;
            else if (dr_acc)
                armed_nxt = '0;
            else
                armed_nxt = armed;
        end else begin
            sw_clr = wr_en ? wr_data : '0;
        end
        any_clr    = hw_clr | sw_clr;
        // Overrun: a new event lands on an already-set flag that is not being
        // cleared this cycle.
        ovr_set    = hw_set & status & ~any_clr;
        ovr_nxt    = ovr_set | (ovr & ~sw_clr);
        status_nxt = hw_set | (status & ~any_clr);
    end

    // State registers with synchronous reset; reset discards any armed sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            status <= RST_STATUS;
            ovr    <= '0;
            armed  <= '0;
        end else begin
            status <= status_nxt;
            ovr    <= ovr_nxt;
            armed  <= armed_nxt;
        end
    end

    // Interrupt follows registered status and the live enable mask.
    always_comb begin
        irq = |(status & irq_en);
    end

endmodule

// File: tb/tb_spi_status_ctrl.sv
// Bench for spi_status_ctrl: one instance per clear mode driven by shared
// inputs, a reference model pushing expected values to a scoreboard queue,
// plus directed constant checks from the test plan.
module tb_spi_status_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] hw_set, hw_clr, wr_data, irq_en;
    logic       sr_rd, dr_acc, wr_en;
    logic [7:0] st0, ov0, st1, ov1;
    logic       irq0, irq1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] st;
        logic [7:0] ov;
        logic       irq;
    } exp_t;

    exp_t       q[$];
    logic [7:0] m_st[2];
    logic [7:0] m_ov[2];
    logic [7:0] m_ar[2];

    always #5 clk = ~clk;

    spi_status_ctrl #(.N_FLAGS(8), .RST_VAL(32'h20), .CLR_MODE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .hw_set(hw_set), .hw_clr(hw_clr),
        .sr_rd(sr_rd), .dr_acc(dr_acc), .wr_en(wr_en), .wr_data(wr_data),
        .irq_en(irq_en), .status(st0), .ovr(ov0), .irq(irq0)
    );

    spi_status_ctrl #(.N_FLAGS(8), .RST_VAL(32'h00), .CLR_MODE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .hw_set(hw_set), .hw_clr(hw_clr),
        .sr_rd(sr_rd), .dr_acc(dr_acc), .wr_en(wr_en), .wr_data(wr_data),
        .irq_en(irq_en), .status(st1), .ovr(ov1), .irq(irq1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; hw_set = '0; hw_clr = '0; sr_rd = 1'b0;
        dr_acc = 1'b0; wr_en = 1'b0; wr_data = '0;
    endtask

    // Model one clock for both instances, push expectations, clock, compare.
    task automatic step();
        exp_t       e;
        logic [7:0] sw, clr;
        for (int d = 0; d < 2; d++) begin
            sw = (d == 1) ? (dr_acc ? m_ar[d] : 8'h00) : (wr_en ? wr_data : 8'h00);
            if (rst) begin
                m_st[d] = (d == 0) ? 8'h20 : 8'h00;
                m_ov[d] = 8'h00;
                m_ar[d] = 8'h00;
            end else begin
                clr     = hw_clr | sw;
                m_ov[d] = (hw_set & m_st[d] & ~clr) | (m_ov[d] & ~sw);
                m_ar[d] = (d == 1) ? (sr_rd ? m_st[d] : (dr_acc ? 8'h00 : m_ar[d])) : 8'h00;
                m_st[d] = hw_set | (m_st[d] & ~clr);
            end
            e.st  = m_st[d];
            e.ov  = m_ov[d];
            e.irq = |(m_st[d] & irq_en);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("sb_status0", st0, e.st);
        chk("sb_ovr0", ov0, e.ov);
        chk("sb_irq0", {7'd0, irq0}, {7'd0, e.irq});
        e = q.pop_front();
        chk("sb_status1", st1, e.st);
        chk("sb_ovr1", ov1, e.ov);
        chk("sb_irq1", {7'd0, irq1}, {7'd0, e.irq});
        idle();
    endtask

    initial begin
        idle();
        irq_en = 8'h00;

        // Reset
        rst = 1'b1; step();
        chk("rst_status0", st0, 8'h20);
        chk("rst_ovr0", ov0, 8'h00);
        chk("rst_irq_off", {7'd0, irq0}, 8'h00);
        irq_en = 8'h20; #1;
        chk("rst_irq_on", {7'd0, irq0}, 8'h01);
        irq_en = 8'h00; #1;

        // Write-1-to-clear mode (dut0); dut1 ignores writes
        wr_en = 1'b1; wr_data = 8'h20; step();
        chk("w1c_clr_rst_bit", st0, 8'h00);
        hw_set = 8'h80; step();
        chk("w1c_set", st0, 8'h80);
        wr_en = 1'b1; wr_data = 8'h80; step();
        chk("w1c_clear", st0, 8'h00);
        chk("seq_ignores_wr", st1, 8'h80);
        hw_set = 8'h80; step();
        wr_en = 1'b1; wr_data = 8'h00; step();
        chk("w1c_zero_write", st0, 8'h80);
        wr_en = 1'b1; wr_data = 8'h80; step();

        // Read-then-access sequence (dut1 holds SPIF)
        sr_rd = 1'b1; step();
        hw_set = 8'h20; step();
        chk("seq_pre_access", st1, 8'hA0);
        dr_acc = 1'b1; step();
        chk("seq_access", st1, 8'h20);
        dr_acc = 1'b1; step();
        chk("seq_second_access", st1, 8'h20);

        // Overrun on dut0
        hw_set = 8'h80; step();
        hw_set = 8'h80; step();
        chk("ovr_set", ov0, 8'h80);
        wr_en = 1'b1; wr_data = 8'h80; step();
        chk("ovr_clr_status", st0 & 8'h80, 8'h00);
        chk("ovr_clr_ovr", ov0, 8'h00);
        hw_set = 8'h80; wr_en = 1'b1; wr_data = 8'h80; step();
        chk("set_vs_swclr_status", st0 & 8'h80, 8'h80);
        chk("set_vs_swclr_ovr", ov0 & 8'h80, 8'h00);

        // Simultaneous set and hardware clear
        hw_set = 8'h20; hw_clr = 8'h20; step();
        chk("set_beats_hwclr", st0 & 8'h20, 8'h20);
        hw_clr = 8'h20; step();
        chk("hwclr_status", st0, 8'h80);
        chk("hwclr_keeps_ovr", ov0, 8'h00);
        chk("hwclr_keeps_ovr1", ov1, 8'h80);

        // Mid-sequence reset on dut1
        chk("mid_pre", st1, 8'h80);
        sr_rd = 1'b1; step();
        rst = 1'b1; step();
        hw_set = 8'h80; step();
        dr_acc = 1'b1; step();
        chk("mid_rst_discard", st1, 8'h80);

        // Random traffic against the model
        for (int n = 0; n < 200; n++) begin
            irq_en  = 8'($urandom);
            hw_set  = 8'($urandom) & 8'($urandom) & 8'($urandom);
            hw_clr  = 8'($urandom) & 8'($urandom) & 8'($urandom);
            sr_rd   = ($urandom_range(0, 3) == 0);
            dr_acc  = ($urandom_range(0, 3) == 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_data = 8'($urandom);
            rst     = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
